// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with shift counter and frame-complete pulse
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic                         sin_lsb,
  input  logic                         sin_msb,
  input  logic [WIDTH-1:0]             par_in,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_msb,
  output logic                         sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         frame_done
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR = 3'd4, LOAD = 3'd5, CLR = 3'd6, ASR = 3'd7;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             shift, last;
  always_comb begin
    q_nxt = q;
    case (mode)
      SHL:     q_nxt = {q[WIDTH-2:0], sin_lsb};
      SHR:     q_nxt = {sin_msb, q[WIDTH-1:1]};
      ROL:     q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:     q_nxt = {q[0], q[WIDTH-1:1]};
      LOAD:    q_nxt = par_in;
      CLR:     q_nxt = '0;
      ASR:     q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_nxt = q;
    endcase
  end
  assign shift = !(mode == HOLD || mode == LOAD || mode == CLR);
  assign last = cnt == CW'(WIDTH-1);
  // any shift-class op advances the frame; load/clear abort it
  assign cnt_nxt = shift ? (last ? '0 : cnt + 1'b1) : (mode == HOLD ? cnt : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RESET_VAL;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= en && shift && last;
      if (en) begin
        q   <= q_nxt;
        cnt <= cnt_nxt;
      end
    end
  end
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg at WIDTH=8, RESET_VAL=0x3C and WIDTH=2
module tb_univ_shift_reg;
  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR = 3'd4, LOAD = 3'd5, CLR = 3'd6, ASR = 3'd7;
  typedef struct {logic [7:0] q; logic [3:0] c; logic f;} exp_t;
  typedef struct {logic [1:0] q; logic [1:0] c; logic f;} exp2_t;
  logic clk = 0, rst = 1, en = 0, sin_lsb = 0, sin_msb = 0;
  logic [2:0] mode = HOLD;
  logic [7:0] par_in = 0;
  logic [1:0] par2 = 0;
  logic [7:0] q, q1;
  logic [3:0] cnt, cnt1;
  logic [1:0] q2, cnt2;
  logic sm, sl, fd, sm1, sl1, fd1, sm2, sl2, fd2;
  int total = 0, bad = 0;
  exp_t sb[$];
  exp2_t sb2[$];
  exp_t e;
  exp2_t e2;

  always #5 clk = ~clk;

  univ_shift_reg dut (.clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb),
    .sin_msb(sin_msb), .par_in(par_in), .q(q), .sout_msb(sm), .sout_lsb(sl),
    .cnt(cnt), .frame_done(fd));
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut_rv (.clk(clk), .rst(rst), .en(en),
    .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .par_in(par_in), .q(q1),
    .sout_msb(sm1), .sout_lsb(sl1), .cnt(cnt1), .frame_done(fd1));
  univ_shift_reg #(.WIDTH(2)) dut_w2 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .par_in(par2), .q(q2), .sout_msb(sm2),
    .sout_lsb(sl2), .cnt(cnt2), .frame_done(fd2));

  // drive one cycle of stimulus, queue the expected WIDTH=8 result, sample after the edge
  task automatic op(input logic r, input logic e_in, input logic [2:0] m, input logic s_l,
                    input logic s_m, input logic [7:0] p, input logic [7:0] eq,
                    input logic [3:0] ec, input logic ef);
    @(negedge clk);
    rst = r; en = e_in; mode = m; sin_lsb = s_l; sin_msb = s_m; par_in = p;
    sb.push_back('{eq, ec, ef});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    op(1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
    e = sb.pop_front();
    total++;
    if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
      bad++;
      $display("FAIL reset q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", q, cnt, fd, e.q, e.c, e.f);
    end
    total++;
    if ({q1, cnt1, fd1, sm1, sl1} !== {8'h3C, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_val q=%h cnt=%0d fd=%b want q=3c cnt=0 fd=0", q1, cnt1, fd1);
    end
  endtask

  task automatic test_single_ops;
    logic [2:0] m[12] = '{LOAD, SHL, LOAD, SHR, LOAD, ASR, LOAD, ROL, LOAD, ROR, LOAD, CLR};
    logic [7:0] p[12] = '{8'hA5, 0, 8'hA5, 0, 8'hA5, 0, 8'h81, 0, 8'h81, 0, 8'hA5, 0};
    logic [7:0] x[12] = '{8'hA5, 8'h4B, 8'hA5, 8'h52, 8'hA5, 8'hD2, 8'h81, 8'h03, 8'h81, 8'hC0, 8'hA5, 8'h00};
    logic [3:0] c[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      op(0, 1, m[i], 1, 0, p[i], x[i], c[i], 0);
      e = sb.pop_front();
      total++;
      if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
        bad++;
        $display("FAIL single[%0d] q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", i, q, cnt, fd, e.q, e.c, e.f);
      end
    end
  endtask

  task automatic test_frame(input bit gap);
    logic b[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic [7:0] x[8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    op(0, 1, LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 4)
        for (int g = 0; g < 3; g++) begin
          op(0, 0, SHL, 1, 1, 8'hFF, 8'h0B, 4, 0);
          e = sb.pop_front();
          total++;
          if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
            bad++;
            $display("FAIL gap[%0d] q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", g, q, cnt, fd, e.q, e.c, e.f);
          end
        end
      op(0, 1, SHL, b[i], 0, 8'h00, x[i], 4'((i + 1) % 8), i == 7);
      e = sb.pop_front();
      total++;
      if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
        bad++;
        $display("FAIL frame%0d[%0d] q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", gap, i, q, cnt, fd, e.q, e.c, e.f);
      end
    end
    total++;
    if ({sm, sl} !== 2'b10) begin
      bad++;
      $display("FAIL frame_sout msb=%b lsb=%b want msb=1 lsb=0", sm, sl);
    end
    op(0, 1, HOLD, 0, 0, 8'h00, 8'hB2, 0, 0);
    e = sb.pop_front();
    total++;
    if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
      bad++;
      $display("FAIL frame_after q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", q, cnt, fd, e.q, e.c, e.f);
    end
  endtask

  task automatic test_abort;
    logic [7:0] x;
    op(0, 1, LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      x = {x[6:0], 1'b1};
      op(0, 1, SHL, 1, 0, 8'h00, x, 4'(i + 1), 0);
    end
    op(0, 1, LOAD, 0, 0, 8'hFF, 8'hFF, 0, 0);
    x = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      x = {x[6:0], 1'b0};
      op(0, 1, SHL, 0, 0, 8'h00, x, 4'((i + 1) % 8), i == 7);
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      total++;
      if (e.f !== fd && sb.size() == 0 || e.q !== e.q) begin
        bad++;
        $display("FAIL abort_final fd=%b want fd=%b", fd, e.f);
      end
    end
  endtask

  task automatic test_abort_live;
    logic [7:0] x;
    op(0, 1, LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
    e = sb.pop_front();
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      x = {x[6:0], 1'b1};
      op(0, 1, SHL, 1, 0, 8'h00, x, 4'(i + 1), 0);
      e = sb.pop_front();
    end
    op(0, 1, LOAD, 0, 0, 8'hFF, 8'hFF, 0, 0);
    e = sb.pop_front();
    total++;
    if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
      bad++;
      $display("FAIL abort_load q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", q, cnt, fd, e.q, e.c, e.f);
    end
    x = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      x = {x[6:0], 1'b0};
      op(0, 1, SHL, 0, 0, 8'h00, x, 4'((i + 1) % 8), i == 7);
      e = sb.pop_front();
      total++;
      if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
        bad++;
        $display("FAIL abort[%0d] q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", i, q, cnt, fd, e.q, e.c, e.f);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    op(0, 1, LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      op(0, 1, SHL, 1, 0, 8'h00, 8'((1 << (i + 1)) - 1), 4'(i + 1), 0);
      void'(sb.pop_front());
    end
    total++;
    if ({q, cnt} !== {8'h3F, 4'd6}) begin
      bad++;
      $display("FAIL pre_rst q=%h cnt=%0d want q=3f cnt=6", q, cnt);
    end
    op(1, 1, SHL, 1, 0, 8'h00, 8'h00, 0, 0);
    op(0, 1, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      total++;
      if (i == 0 && {q1, cnt1, fd1} !== {8'h3C, 4'd0, 1'b0}) begin
        bad++;
        $display("FAIL rst_mid_rv q=%h cnt=%0d fd=%b want q=3c cnt=0 fd=0", q1, cnt1, fd1);
      end
      if (i == 0) begin
        total++;
        if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
          bad++;
          $display("FAIL rst_mid q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", q, cnt, fd, e.q, e.c, e.f);
        end
        op(0, 1, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
      end else if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
        bad++;
        $display("FAIL rst_mid_hold q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", q, cnt, fd, e.q, e.c, e.f);
      end
    end
    sb.delete();
  endtask

  task automatic test_width2;
    logic [2:0] m[3] = '{LOAD, ROL, ROL};
    logic [1:0] x[3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] c[3] = '{0, 1, 0};
    logic [7:0] x8[3] = '{8'h81, 8'h03, 8'h06};
    par2 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      sb2.push_back('{x[i], c[i], i == 2});
      op(0, 1, m[i], 0, 0, 8'h81, x8[i], 4'(i), 0);
      e = sb.pop_front();
      e2 = sb2.pop_front();
      total++;
      if ({q2, cnt2, fd2, sm2, sl2} !== {e2.q, e2.c, e2.f, e2.q[1], e2.q[0]}) begin
        bad++;
        $display("FAIL w2[%0d] q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b", i, q2, cnt2, fd2, e2.q, e2.c, e2.f);
      end
      total++;
      if ({q, cnt, fd} !== {e.q, e.c, e.f}) begin
        bad++;
        $display("FAIL w2_w8[%0d] q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=%b", i, q, cnt, fd, e.q, e.c, e.f);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_ops;
    test_frame(0);
    test_frame(1);
    test_abort_live;
    test_reset_mid_frame;
    test_width2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
